// File: rtl/uc_gera_asteroides_n_pkg.sv
// uc_gera_asteroides_n_pkg: state codes and defaults shared by the asteroid spawn controller.
package uc_gera_asteroides_n_pkg;
   localparam int N_SLOTS_DEF = 8;
   typedef enum logic [3:0] {
      INICIAL    = 4'h0,
      ESPERA     = 4'h1,
      CARREGA    = 4'h2,
      VERIFICA   = 4'h3,
      PROXIMO    = 4'h4,
      SALVA      = 4'h5,
      ESPERA_MEM = 4'h6,
      SINALIZA   = 4'h7,
      ERRO       = 4'hF
   } estado_t;
endpackage

// File: rtl/uc_gera_asteroides_n_contador.sv
// uc_gera_asteroides_n_contador: modulo-M up-counter with synchronous clear and enable.
module uc_gera_asteroides_n_contador #(
   parameter int M = 2,
   parameter int W = 1
)(
   input  logic clock_i,
   input  logic reset_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic fim_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign fim_o = cnt_q == W'(M - 1);
   assign cnt_d = clr_i ? '0 : !en_i ? cnt_q : fim_o ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uc_gera_asteroides_n.sv
// uc_gera_asteroides_n: places up to quantidade asteroids in free slots per request,
// scanning round-robin from the slot after the last one written.
module uc_gera_asteroides_n
   import uc_gera_asteroides_n_pkg::*;
#(
   parameter int N_SLOTS = N_SLOTS_DEF,
   parameter int MEM_LAT = 1,
   parameter int PERIODO = 64,
   localparam int IW = $clog2(N_SLOTS),
   localparam int QW = $clog2(N_SLOTS + 1)
)(
   input  logic               clock_i,
   input  logic               reset_n_i,
   input  logic               gera_asteroide_i,
   input  logic               modo_auto_i,
   input  logic [QW-1:0]      quantidade_i,
   input  logic [N_SLOTS-1:0] ocupado_i,
   output logic               busy_o,
   output logic               enable_mem_aste_o,
   output logic               enable_load_aste_o,
   output logic [IW-1:0]      endereco_aste_o,
   output logic               fim_gera_asteroide_o,
   output logic               cheio_o,
   output logic [QW-1:0]      num_gerados_o,
   output logic [3:0]         db_estado_o
);
   localparam logic [IW:0]   FULL = (IW + 1)'(N_SLOTS);
   localparam logic [IW-1:0] LAST = IW'(N_SLOTS - 1);

   estado_t            state_q, state_d;
   logic [IW-1:0]      idx_q, ptr_q, end_q, idx_inc;
   logic [IW:0]        varridos_q;
   logic [QW-1:0]      restante_q, num_q;
   logic [N_SLOTS-1:0] reserva_q;
   logic               strobe_q, fim_q, busy_q, cheio_q;
   logic               timer_fim, wcnt_fim, pedido, livre;

   uc_gera_asteroides_n_contador #(.M(PERIODO), .W($clog2(PERIODO))) u_timer (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .clr_i     (state_q == INICIAL || state_q == SINALIZA || !modo_auto_i),
      .en_i      (state_q == ESPERA),
      .fim_o     (timer_fim)
   );

   uc_gera_asteroides_n_contador #(.M(MEM_LAT), .W($clog2(MEM_LAT + 1))) u_wcnt (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .clr_i     (state_q == SALVA),
      .en_i      (state_q == ESPERA_MEM),
      .fim_o     (wcnt_fim)
   );

   assign idx_inc = (idx_q == LAST) ? '0 : idx_q + 1'b1;
   // reserva hides slots written this request even if ocupado has not caught up yet
   assign livre   = !(ocupado_i[idx_q] || reserva_q[idx_q]);
   assign pedido  = gera_asteroide_i || (modo_auto_i && timer_fim);

   always_comb begin
      state_d = ERRO;
      case (state_q)
         INICIAL:    state_d = ESPERA;
         ESPERA:     state_d = pedido ? CARREGA : ESPERA;
         CARREGA:    state_d = VERIFICA;
         VERIFICA:   state_d = (restante_q == '0 || varridos_q == FULL) ? SINALIZA : livre ? SALVA : PROXIMO;
         PROXIMO:    state_d = VERIFICA;
         SALVA:      state_d = ESPERA_MEM;
         ESPERA_MEM: state_d = wcnt_fim ? VERIFICA : ESPERA_MEM;
         SINALIZA:   state_d = ESPERA;
         default:    state_d = ERRO;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= INICIAL;
         idx_q      <= '0;
         ptr_q      <= '0;
         end_q      <= '0;
         varridos_q <= '0;
         restante_q <= '0;
         num_q      <= '0;
         reserva_q  <= '0;
         strobe_q   <= 1'b0;
         fim_q      <= 1'b0;
         busy_q     <= 1'b0;
         cheio_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         strobe_q <= state_d == SALVA;
         fim_q    <= state_d == SINALIZA;
         busy_q   <= !(state_d inside {INICIAL, ESPERA});
         if (state_d == SALVA) end_q <= idx_q;
         if (state_q == CARREGA) begin
            restante_q <= quantidade_i;
            idx_q      <= ptr_q;
            varridos_q <= '0;
            reserva_q  <= '0;
            cheio_q    <= 1'b0;
            num_q      <= '0;
         end
         if (state_q == VERIFICA && state_d == SINALIZA && restante_q != '0) cheio_q <= 1'b1;
         if (state_q == PROXIMO) begin
            idx_q      <= idx_inc;
            varridos_q <= varridos_q + 1'b1;
         end
         if (state_q == SALVA) begin
            reserva_q[idx_q] <= 1'b1;
            restante_q       <= restante_q - 1'b1;
            num_q            <= num_q + 1'b1;
            varridos_q       <= '0;
            ptr_q            <= idx_inc;
            idx_q            <= idx_inc;
         end
      end
   end

   assign busy_o               = busy_q;
   assign enable_mem_aste_o    = strobe_q;
   assign enable_load_aste_o   = strobe_q;
   assign endereco_aste_o      = end_q;
   assign fim_gera_asteroide_o = fim_q;
   assign cheio_o              = cheio_q;
   assign num_gerados_o        = num_q;
   assign db_estado_o          = state_q;
endmodule

// File: tb/tb_uc_gera_asteroides_n.sv
// tb_uc_gera_asteroides_n: directed and randomized requests checked against a slot-list
// and latency model of the spawn controller (N_SLOTS=8, MEM_LAT=1, PERIODO=16).
module tb_uc_gera_asteroides_n;
   localparam int MEM_LAT = 1;

   logic       clk, rst_n, gera, auto_m;
   logic [3:0] qt_s;
   logic [7:0] occ_s;
   logic       busy, en_mem, en_load, fim, cheio;
   logic [2:0] endr;
   logic [3:0] num, db;

   int checks = 0, failures = 0;
   int ptr_m;
   int e_addr[$], e_t[$];
   int e_fim, e_num;
   bit e_cheio;

   uc_gera_asteroides_n #(.N_SLOTS(8), .MEM_LAT(MEM_LAT), .PERIODO(16)) dut (
      .clock_i              (clk),
      .reset_n_i            (rst_n),
      .gera_asteroide_i     (gera),
      .modo_auto_i          (auto_m),
      .quantidade_i         (qt_s),
      .ocupado_i            (occ_s),
      .busy_o               (busy),
      .enable_mem_aste_o    (en_mem),
      .enable_load_aste_o   (en_load),
      .endereco_aste_o      (endr),
      .fim_gera_asteroide_o (fim),
      .cheio_o              (cheio),
      .num_gerados_o        (num),
      .db_estado_o          (db)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Free slots in round-robin order from ptr; first strobe 2 samples after CARREGA,
   // every skipped slot costs 2 cycles, every write MEM_LAT+2, a full fruitless scan 16.
   function automatic void model(input logic [7:0] occ, input int qt);
      int order[$];
      int t, prev, d;
      t = 0;
      prev = 0;
      e_addr.delete();
      e_t.delete();
      for (int i = 0; i < 8; i++) if (!occ[(ptr_m + i) % 8]) order.push_back((ptr_m + i) % 8);
      e_num   = qt < order.size() ? qt : order.size();
      e_cheio = qt > order.size();
      for (int j = 0; j < e_num; j++) begin
         d = (j == 0) ? (order[j] - ptr_m + 8) % 8 : (order[j] - prev + 7) % 8;
         t = ((j == 0) ? 2 : t + MEM_LAT + 2) + 2 * d;
         e_addr.push_back(order[j]);
         e_t.push_back(t);
         prev = order[j];
      end
      if (e_num > 0) ptr_m = (prev + 1) % 8;
      e_fim = ((e_num == 0) ? 2 : t + MEM_LAT + 2) + (e_cheio ? 16 : 0);
   endfunction

   task automatic wait_espera(input string tag);
      int ok = 0;
      for (int i = 0; i < 50 && ok == 0; i++) begin
         @(negedge clk);
         if (db == 4'd1) ok = 1;
      end
      chk({tag, "_espera_timeout"}, ok, 1);
   endtask

   // Called right after the CARREGA sample; follows the request until fim.
   task automatic watch(input string tag);
      int got_a[$], got_t[$];
      int fim_t = -1;
      int load_bad = 0;
      for (int n = 1; n <= 200 && fim_t < 0; n++) begin
         @(posedge clk); #1;
         if (en_load !== en_mem) load_bad = 1;
         if (en_mem === 1'b1) begin
            got_a.push_back(int'(endr));
            got_t.push_back(n);
         end
         if (fim === 1'b1) fim_t = n;
      end
      chk({tag, "_fim_t"}, fim_t, e_fim);
      chk({tag, "_n_strobes"}, got_a.size(), e_addr.size());
      for (int i = 0; i < got_a.size() && i < e_addr.size(); i++) begin
         chk({tag, "_addr"}, got_a[i], e_addr[i]);
         chk({tag, "_strobe_t"}, got_t[i], e_t[i]);
      end
      chk({tag, "_cheio"}, cheio, e_cheio);
      chk({tag, "_num"}, num, e_num);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_load_eq_mem"}, load_bad, 0);
   endtask

   task automatic req(input logic [7:0] occ, input int qt, input string tag);
      occ_s = occ;
      qt_s  = 4'(qt);
      model(occ, qt);
      wait_espera(tag);
      gera = 1'b1;
      @(posedge clk); #1;
      gera = 1'b0;
      chk({tag, "_carrega"}, db, 2);
      watch(tag);
   endtask

   task automatic count_espera(input string tag);
      int cnt = 0;
      int run = 1;
      for (int i = 0; i < 100 && run == 1; i++) begin
         @(posedge clk); #1;
         if (db == 4'd1) cnt++;
         else run = 0;
      end
      chk({tag, "_espera_cycles"}, cnt, 16);
      chk({tag, "_carrega"}, db, 2);
   endtask

   initial begin
      rst_n = 1'b1; gera = 1'b0; auto_m = 1'b0; qt_s = '0; occ_s = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_outs", {busy, en_mem, en_load, endr, fim, cheio, num}, 0);
      chk("reset_state", db, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;

      req(8'h00, 1, "t1_single");
      req(8'b0000_0110, 2, "t2_skip");
      req(8'hFF, 3, "t3_full");
      req(8'b1011_1111, 1, "t4_setptr");
      req(8'b1111_1100, 3, "t4_wrap");
      req(8'h00, 0, "qt_zero");
      req(8'h00, 12, "qt_over");
      for (int r = 0; r < 10; r++) req(8'($urandom), int'($urandom_range(0, 10)), "rand");

      occ_s = '0;
      qt_s = 4'd1;
      auto_m = 1'b1;
      req(8'h00, 1, "auto_seed");
      count_espera("auto1");
      model(8'h00, 1);
      gera = 1'b1;
      watch("auto1_gera_held");
      gera = 1'b0;
      count_espera("auto2");
      model(8'h00, 1);
      watch("auto2");
      auto_m = 1'b0;

      occ_s = '0;
      qt_s = 4'd3;
      wait_espera("rst_mid");
      gera = 1'b1;
      @(posedge clk); #1;
      gera = 1'b0;
      begin
         int seen = 0;
         for (int i = 0; i < 20 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (db == 4'd6) seen = 1;
         end
         chk("rst_mid_reach_espera_mem", seen, 1);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", {busy, en_mem, en_load, endr, fim, cheio, num}, 0);
      chk("rst_mid_state", db, 0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_hold", {en_mem, fim, db}, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;
      req(8'h00, 1, "after_reset");
      req(8'b0000_0001, 2, "after_reset2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
